// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the Chip-8 4 KiB work RAM between loader, blitter and CPU
//
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN
//   defined   -> blitter/CPU contention is resolved round-robin
//   undefined -> fixed priority, blitter over CPU (no pointer register)
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   ld_req/ld_addr/ld_wdata/ld_ack   loader write port
//   blit_req/blit_addr/blit_ack      blitter read port, blit_rvalid marks its data
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata/cpu_ack   CPU read/write port, cpu_rvalid marks its data
//   rdata                            shared read data (straight from mem_rdata)
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata  synchronous RAM primitive
//   busy                             a read is travelling through the tag pipeline
module ram_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_req,
    input  logic [11:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        ld_ack,
    input  logic        blit_req,
    input  logic [11:0] blit_addr,
    output logic        blit_ack,
    output logic        blit_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_BLIT = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;

    logic                        blit_gnt, cpu_gnt;
    logic                        mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [11:0]                 mem_addr_q, mem_addr_d;
    logic [7:0]                  mem_wdata_q, mem_wdata_d;
    logic [1:0]                  tag_in;
    logic [MEM_LATENCY-1:0][1:0] tag_q, tag_d;
    logic                        blit_rvalid_q, cpu_rvalid_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // cpu_last_q=1 means the CPU was served last, so the blitter wins the next tie
    logic cpu_last_q, cpu_last_d;

    always_comb begin
        blit_gnt   = !ld_req && blit_req && (!cpu_req || cpu_last_q);
        cpu_gnt    = !ld_req && cpu_req && !blit_gnt;
        cpu_last_d = (blit_gnt || cpu_gnt) ? cpu_gnt : cpu_last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cpu_last_q <= 1'b1;
        else          cpu_last_q <= cpu_last_d;
    end
`else
    assign blit_gnt = !ld_req && blit_req;
    assign cpu_gnt  = !ld_req && !blit_req && cpu_req;
`endif

    assign ld_ack   = ld_req;
    assign blit_ack = blit_gnt;
    assign cpu_ack  = cpu_gnt;

    // Address/data registers hold when idle or, for wdata, on reads
    always_comb begin
        mem_en_d    = ld_req || blit_gnt || cpu_gnt;
        mem_wr_d    = ld_req || (cpu_gnt && cpu_wr);
        mem_addr_d  = ld_req ? ld_addr : blit_gnt ? blit_addr : cpu_gnt ? cpu_addr : mem_addr_q;
        mem_wdata_d = ld_req ? ld_wdata : (cpu_gnt && cpu_wr) ? cpu_wdata : mem_wdata_q;
        tag_in      = blit_gnt ? TAG_BLIT : (cpu_gnt && !cpu_wr) ? TAG_CPU : TAG_NONE;
    end

    // Owner tags ride alongside the RAM latency; the final register lines the
    // rvalid strobes up with mem_rdata
    always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < MEM_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tag_q         <= '0;
            blit_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            mem_en_q      <= mem_en_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            tag_q         <= tag_d;
            blit_rvalid_q <= tag_q[MEM_LATENCY-1] == TAG_BLIT;
            cpu_rvalid_q  <= tag_q[MEM_LATENCY-1] == TAG_CPU;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign blit_rvalid = blit_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign rdata       = mem_rdata;
    assign busy        = |tag_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector bench for ram_arbiter (latency 1 and latency 3 instances)
module tb_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        ld_req, blit_req, cpu_req, cpu_wr;
    logic [11:0] ld_addr, blit_addr, cpu_addr;
    logic [7:0]  ld_wdata, cpu_wdata;
    logic        ld_ack, blit_ack, blit_rvalid, cpu_ack, cpu_rvalid;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, busy;
    logic [11:0] mem_addr;

    logic        ld3_req, blit3_req, cpu3_req, cpu3_wr;
    logic [11:0] ld3_addr, blit3_addr, cpu3_addr;
    logic [7:0]  ld3_wdata, cpu3_wdata;
    logic        ld3_ack, blit3_ack, blit3_rvalid, cpu3_ack, cpu3_rvalid;
    logic [7:0]  rdata3, mem3_wdata, mem3_rdata;
    logic        mem3_en, mem3_wr, busy3;
    logic [11:0] mem3_addr;

    ram_arbiter #(.MEM_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .blit_req(blit_req), .blit_addr(blit_addr), .blit_ack(blit_ack), .blit_rvalid(blit_rvalid),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    ram_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .ld_req(ld3_req), .ld_addr(ld3_addr), .ld_wdata(ld3_wdata), .ld_ack(ld3_ack),
        .blit_req(blit3_req), .blit_addr(blit3_addr), .blit_ack(blit3_ack), .blit_rvalid(blit3_rvalid),
        .cpu_req(cpu3_req), .cpu_wr(cpu3_wr), .cpu_addr(cpu3_addr), .cpu_wdata(cpu3_wdata),
        .cpu_ack(cpu3_ack), .cpu_rvalid(cpu3_rvalid), .rdata(rdata3),
        .mem_en(mem3_en), .mem_wr(mem3_wr), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
        .mem_rdata(mem3_rdata), .busy(busy3)
    );

    // RAM model: fixed preload contents, overridden by anything written
    logic [7:0] wmem [logic [11:0]];
    logic [7:0] p3 [3];

    function automatic logic [7:0] preload(input logic [11:0] a);
        case (a)
            12'h200: return 8'h12;
            12'h100: return 8'h77;
            12'hFFF: return 8'hE1;
            12'h300: return 8'h33;
            12'h301: return 8'h34;
            12'h400, 12'h401, 12'h402, 12'h403: return 8'h40 + {6'd0, a[1:0]};
            12'h500, 12'h501, 12'h502, 12'h503: return 8'h50 + {6'd0, a[1:0]};
            default: return a[7:0];
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [11:0] a);
        return wmem.exists(a) ? wmem[a] : preload(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_wr) wmem[mem_addr] = mem_wdata;
        else if (mem_en) mem_rdata <= rd(mem_addr);
        if (mem3_en) p3[0] <= rd(mem3_addr);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem3_rdata = p3[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic ld; logic [11:0] la; logic [7:0] lw;
        logic bl; logic [11:0] ba;
        logic cp; logic cw; logic [11:0] ca; logic [7:0] cd;
        logic e_la, e_ba, e_ca;
        logic e_en, e_wr; logic [11:0] e_addr; logic [7:0] e_wd;
        logic e_brv, e_crv, e_busy;
        logic chk_rd; logic [7:0] e_rd;
    } vec_t;

    vec_t v [15];

    task automatic reset_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic exp_b;
        int eb, ec, nb, nc;
        logic [1:0] own_h [8];
        logic [7:0] dat_h [8];

        reset_n = 1'b0;
        {ld_req, blit_req, cpu_req, cpu_wr} = '0;
        {ld_addr, blit_addr, cpu_addr, ld_wdata, cpu_wdata} = '0;
        {ld3_req, blit3_req, cpu3_req, cpu3_wr} = '0;
        {ld3_addr, blit3_addr, cpu3_addr, ld3_wdata, cpu3_wdata} = '0;

        //             ld la      lw     bl ba      cp cw ca      cd      la ba ca en wr addr    wd     brv crv bsy rd e_rd
        v[0]  = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h00};
        v[1]  = '{0, 12'h000, 8'h00, 0, 12'h000, 1, 0, 12'h200, 8'h00, 0, 0, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 8'h00};
        v[2]  = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 0, 12'h200, 8'h00, 0, 0, 1, 0, 8'h00};
        v[3]  = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 12'h200, 8'h00, 0, 1, 0, 1, 8'h12};
        v[4]  = '{1, 12'h050, 8'hAB, 1, 12'h100, 1, 0, 12'h201, 8'h00, 1, 0, 0, 0, 0, 12'h200, 8'h00, 0, 0, 0, 0, 8'h00};
        v[5]  = '{0, 12'h050, 8'hAB, 1, 12'h100, 1, 0, 12'h201, 8'h00, 0, 1, 0, 1, 1, 12'h050, 8'hAB, 0, 0, 0, 0, 8'h00};
        v[6]  = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 0, 12'h100, 8'hAB, 0, 0, 1, 0, 8'h00};
        v[7]  = '{0, 12'h000, 8'h00, 0, 12'h000, 1, 0, 12'h050, 8'h00, 0, 0, 1, 0, 0, 12'h100, 8'hAB, 1, 0, 0, 1, 8'h77};
        v[8]  = '{0, 12'h000, 8'h00, 0, 12'h000, 1, 1, 12'h123, 8'h5C, 0, 0, 1, 1, 0, 12'h050, 8'hAB, 0, 0, 1, 0, 8'h00};
        v[9]  = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 1, 12'h123, 8'h5C, 0, 1, 0, 1, 8'hAB};
        v[10] = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 12'h123, 8'h5C, 0, 0, 0, 0, 8'h00};
        v[11] = '{0, 12'h000, 8'h00, 0, 12'h000, 1, 0, 12'h123, 8'h00, 0, 0, 1, 0, 0, 12'h123, 8'h5C, 0, 0, 0, 0, 8'h00};
        v[12] = '{0, 12'h000, 8'h00, 1, 12'hFFF, 0, 0, 12'h000, 8'h00, 0, 1, 0, 1, 0, 12'h123, 8'h5C, 0, 0, 1, 0, 8'h00};
        v[13] = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 1, 0, 12'hFFF, 8'h5C, 0, 1, 1, 1, 8'h5C};
        v[14] = '{0, 12'h000, 8'h00, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 0, 0, 12'hFFF, 8'h5C, 1, 0, 0, 1, 8'hE1};

        // Reset state, and an ack during reset must not issue anything
        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_en", 32'(mem_en), 32'(0));
        chk("rst mem_wr", 32'(mem_wr), 32'(0));
        chk("rst mem_addr", 32'(mem_addr), 32'(0));
        chk("rst mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst busy", 32'(busy), 32'(0));
        chk("rst rvalids", 32'({blit_rvalid, cpu_rvalid}), 32'(0));
        chk("rst busy3", 32'(busy3), 32'(0));
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 12'h777; cpu_wdata = 8'h99;
        #1 chk("rst cpu_ack comb", 32'(cpu_ack), 32'(1));
        @(negedge clk);
        #1;
        chk("rst no issue en", 32'(mem_en), 32'(0));
        chk("rst no issue addr", 32'(mem_addr), 32'(0));
        @(negedge clk);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ld_req = v[i].ld; ld_addr = v[i].la; ld_wdata = v[i].lw;
            blit_req = v[i].bl; blit_addr = v[i].ba;
            cpu_req = v[i].cp; cpu_wr = v[i].cw; cpu_addr = v[i].ca; cpu_wdata = v[i].cd;
            #1;
            chk($sformatf("v%0d ld_ack", i), 32'(ld_ack), 32'(v[i].e_la));
            chk($sformatf("v%0d blit_ack", i), 32'(blit_ack), 32'(v[i].e_ba));
            chk($sformatf("v%0d cpu_ack", i), 32'(cpu_ack), 32'(v[i].e_ca));
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(v[i].e_en));
            chk($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(v[i].e_wr));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(v[i].e_addr));
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(v[i].e_wd));
            chk($sformatf("v%0d blit_rvalid", i), 32'(blit_rvalid), 32'(v[i].e_brv));
            chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(v[i].e_crv));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(v[i].e_busy));
            if (v[i].chk_rd) chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(v[i].e_rd));
        end

        // Contended burst: 4 blit reads and 4 cpu reads held continuously
        reset_pulse();
        eb = 0; ec = 0; nb = 0; nc = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            blit_req = nb < 4; blit_addr = 12'h400 + 12'(nb);
            cpu_req = nc < 4; cpu_wr = 1'b0; cpu_addr = 12'h500 + 12'(nc);
            #1;
            if (c >= 2 && c < 10) begin
                chk($sformatf("burst c%0d blit_rvalid", c), 32'(blit_rvalid), 32'(own_h[c-2] == 2'd1));
                chk($sformatf("burst c%0d cpu_rvalid", c), 32'(cpu_rvalid), 32'(own_h[c-2] == 2'd2));
                chk($sformatf("burst c%0d rdata", c), 32'(rdata), 32'(dat_h[c-2]));
            end
            if (c < 8) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                exp_b = (c % 2) == 0;
`else
                exp_b = c < 4;
`endif
                chk($sformatf("burst c%0d blit_ack", c), 32'(blit_ack), 32'(exp_b));
                chk($sformatf("burst c%0d cpu_ack", c), 32'(cpu_ack), 32'(!exp_b));
                own_h[c] = exp_b ? 2'd1 : 2'd2;
                dat_h[c] = exp_b ? 8'h40 + 8'(eb) : 8'h50 + 8'(ec);
                if (exp_b) eb++; else ec++;
                if (blit_ack) nb++;
                if (cpu_ack) nc++;
            end
        end
        blit_req = 1'b0; cpu_req = 1'b0;

        // Reset one cycle after a cpu read ack: the read must vanish
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h210;
        #1 chk("midrst cpu_ack", 32'(cpu_ack), 32'(1));
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("midrst issued en", 32'(mem_en), 32'(1));
        chk("midrst issued addr", 32'(mem_addr), 32'(12'h210));
        #1 reset_n = 1'b0;
        #1;
        chk("midrst mem_en", 32'(mem_en), 32'(0));
        chk("midrst mem_wr", 32'(mem_wr), 32'(0));
        chk("midrst mem_addr", 32'(mem_addr), 32'(0));
        chk("midrst mem_wdata", 32'(mem_wdata), 32'(0));
        chk("midrst busy", 32'(busy), 32'(0));
        chk("midrst rvalids", 32'({blit_rvalid, cpu_rvalid}), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midrst after%0d cpu_rvalid", j), 32'(cpu_rvalid), 32'(0));
            chk($sformatf("midrst after%0d busy", j), 32'(busy), 32'(0));
        end

        // Latency 3: back-to-back cpu reads of 0x300/0x301
        @(negedge clk);
        cpu3_req = 1'b1; cpu3_wr = 1'b0; cpu3_addr = 12'h300;
        #1 chk("lat3 ack0", 32'(cpu3_ack), 32'(1));
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            cpu3_req = j == 1; cpu3_addr = 12'h301;
            #1;
            if (j == 1) chk("lat3 ack1", 32'(cpu3_ack), 32'(1));
            chk($sformatf("lat3 N+%0d cpu_rvalid", j), 32'(cpu3_rvalid), 32'(j == 4 || j == 5));
            chk($sformatf("lat3 N+%0d busy", j), 32'(busy3), 32'(j <= 4));
            if (j == 4) chk("lat3 N+4 rdata", 32'(rdata3), 32'(8'h33));
            if (j == 5) chk("lat3 N+5 rdata", 32'(rdata3), 32'(8'h34));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single 4 KiB Chip-8 work RAM (12-bit address, 8-bit data) between three requesters: the ROM/font loader, the blitter's sprite fetch, and the CPU's fetch/load/store/BCD traffic. It sits between those masters and the synchronous RAM primitive. It issues at most one access per clock and returns read data to the owning requester after a fixed memory latency.

## Interface
- MEM_LATENCY, 1: cycles from a command being visible on mem_* to mem_rdata being valid (1..4)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ld_req  in  1  loader write request (write-only port)
- ld_addr  in  12  loader address
- ld_wdata  in  8  loader write data
- ld_ack  out  1  loader command accepted this cycle
- blit_req  in  1  blitter read request (read-only port)
- blit_addr  in  12  blitter address
- blit_ack  out  1  blitter command accepted this cycle
- blit_rvalid  out  1  rdata belongs to blitter this cycle
- cpu_req  in  1  CPU request
- cpu_wr  in  1  CPU write (1) / read (0)
- cpu_addr  in  12  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  CPU command accepted this cycle
- cpu_rvalid  out  1  rdata belongs to CPU this cycle
- rdata  out  8  shared read data, combinationally equal to mem_rdata
- mem_en  out  1  RAM enable
- mem_wr  out  1  RAM write enable
- mem_addr  out  12  RAM address
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data
- busy  out  1  a read is in flight (any tag-pipeline stage occupied)

## Operation
- Requester rule: hold req and address/data stable until ack is sampled high. Ack is a combinational one-cycle pulse. The requester may change or drop req on the following cycle. Keeping req high after ack requests another access, so bursts run one access per cycle.
- Grant, evaluated every cycle: ld_req wins unconditionally. Otherwise blit/cpu arbitration follows the Configuration section. Exactly one ack at most per cycle.
- Issue: at the edge ending an ack cycle, mem_en=1, mem_wr=(loader or cpu_wr), and mem_addr and mem_wdata are loaded from the winner. For a read, mem_wdata holds its previous value.
- No grant: mem_en=0 and mem_wr=0. mem_addr and mem_wdata hold their values.
- Read tagging: a MEM_LATENCY-deep shift register carries the owner tag {none, blit, cpu}. The tag is entered at issue. The rvalid of the tagged owner is driven from the last stage. Writes enter tag none.
- Loader writes produce no rvalid. A CPU write produces no cpu_rvalid.

## Timing
- Reset (asynchronous, while reset_n=0):
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - All tags none, so all rvalid=0 and busy=0.
  - Round-robin pointer = "cpu last served".
  - Acks are combinational, so they may be high while reset_n=0 if a req is high. Nothing is issued until reset_n has been 1 at a clock edge.
- Reset mid-burst: in-flight reads are discarded and no rvalid is produced for them. Requesters must re-request.
- Latency: ack in cycle N, command on mem_* in N+1, rvalid and rdata in N+1+MEM_LATENCY. With the default this is N+2.
- Throughput: one access per cycle, reads and writes mixed with no bubble.
- A read to an address written by the immediately preceding command returns whatever the RAM primitive returns. The arbiter does no forwarding.
- Simultaneous ld/blit/cpu requests: the loader is acked. The other two keep waiting, and the pointer does not move.
- Widths: all addresses are 12-bit and wrap naturally. The arbiter never increments addresses.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined:
  - When blit_req and cpu_req are both high (no ld_req), grant the one not served last. The pointer updates only on a blit or cpu grant.
  - A lone requester is granted every cycle.
- RAM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: blit over cpu. The CPU may starve during a sprite fetch.
  - The pointer register is not built.

## Test plan
- Reset, then cpu read at 0x200 with mem holding 0x12: cpu_ack in cycle N, mem_en=1 and mem_addr=0x200 in N+1, cpu_rvalid=1 and rdata=0x12 in N+2, busy=1 in N+1 only.
- Loader writes 0xAB to 0x050 while cpu_req and blit_req are both high: ld_ack first, mem_wr=1 with mem_wdata=0xAB. No rvalid is produced for the write. The pointer is unchanged.
- Round-robin on: blit and cpu both request 4 reads each, held continuously. Acks alternate blit, cpu, blit, cpu… (blit first after reset). Each rvalid pairs with the correct rdata 2 cycles later.
- Round-robin off, same stimulus: 4 blit acks, then 4 cpu acks. cpu_ack stays 0 while blit_req is high.
- Assert reset_n=0 one cycle after a cpu read ack: no cpu_rvalid ever appears for it. mem_en=0 immediately, all outputs at reset values.
- MEM_LATENCY=3, back-to-back cpu reads of 0x300/0x301: cpu_rvalid is high in N+4 and N+5 with matching data.
